// File: rtl/my_riscv_defines.sv
// Shared RV32I constants: opcodes, CSR addresses, funct3/imm encodings, trap causes, trap FSM states.
// MY_RISCV_IRQ_EN makes mip a known CSR address.
package my_riscv_defines;

  localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MISA    = 12'h301;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [2:0]  F3_PRIV     = 3'b000;
  localparam logic [2:0]  F3_CSRRW    = 3'b001;
  localparam logic [2:0]  F3_CSRRS    = 3'b010;
  localparam logic [2:0]  F3_CSRRC    = 3'b011;
  localparam logic [2:0]  F3_CSRRWI   = 3'b101;
  localparam logic [2:0]  F3_CSRRSI   = 3'b110;
  localparam logic [2:0]  F3_CSRRCI   = 3'b111;

  localparam logic [11:0] IMM_ECALL   = 12'h000;
  localparam logic [11:0] IMM_MRET    = 12'h302;
  localparam logic [11:0] IMM_WFI     = 12'h105;

  localparam logic [4:0]  CAUSE_INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0]  CAUSE_ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0]  CAUSE_ECALL_M          = 5'd11;
  localparam logic [4:0]  INT_M_EXT              = 5'd11;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MEIE_BIT = 11;

  // MPP is hardwired to machine mode, so these bits always read as set.
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

  typedef enum logic [1:0] {RUN, TRAP, RET, WFI} trap_state_e;

  function automatic logic [31:0] mk_cause(input logic intr, input logic [4:0] code);
    return {intr, 26'b0, code};
  endfunction

  function automatic logic csr_known(input logic [11:0] addr);
    logic known;
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL: known = 1'b1;
`ifdef MY_RISCV_IRQ_EN
      CSR_MIP:                         known = 1'b1;
`endif
      default:                         known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/my_riscv_trap_ctrl_if.sv
// EX-stage bus between the pipeline (master) and the trap controller (slave).
// MY_RISCV_IRQ_EN adds the external interrupt line irq_ext.
interface my_riscv_trap_ctrl_if;
  logic        ex_valid;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic        ex_illegal;
  logic        ex_misaligned;
  logic [31:0] ex_bad_addr;
  logic [31:0] csr_rdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
`ifdef MY_RISCV_IRQ_EN
  logic        irq_ext;
`endif

  modport master (
`ifdef MY_RISCV_IRQ_EN
    output irq_ext,
`endif
    output ex_valid, ex_instr, ex_pc, ex_rs1_data, ex_illegal, ex_misaligned, ex_bad_addr,
    input  csr_rdata, flush, redirect_valid, redirect_pc, stall
  );

  modport slave (
`ifdef MY_RISCV_IRQ_EN
    input  irq_ext,
`endif
    input  ex_valid, ex_instr, ex_pc, ex_rs1_data, ex_illegal, ex_misaligned, ex_bad_addr,
    output csr_rdata, flush, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/my_riscv_csr_regfile.sv
// Machine-mode CSR storage with WARL masking and the read mux.
// MY_RISCV_IRQ_EN adds the mip mirror of irq_ext and exports MIE/MEIE.
module my_riscv_csr_regfile
  import my_riscv_defines::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MY_RISCV_IRQ_EN
  input  logic        i_irqExt,
  output logic        o_mstatusMie,
  output logic        o_mieMeie,
`endif
  input  logic [11:0] i_addr,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic        i_trap,
  input  logic [31:0] i_trapPc,
  input  logic [31:0] i_trapCause,
  input  logic [31:0] i_trapVal,
  input  logic        i_mret,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);

  logic        r_mstatusMie;
  logic        r_mstatusMpie;
  logic        r_mieMeie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] w_mstatus;
  logic [31:0] w_mie;

  always_comb begin
    w_mstatus           = MSTATUS_FIXED;
    w_mstatus[MIE_BIT]  = r_mstatusMie;
    w_mstatus[MPIE_BIT] = r_mstatusMpie;
    w_mie               = '0;
    w_mie[MEIE_BIT]     = r_mieMeie;
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      CSR_MSTATUS: o_rdata = w_mstatus;
      CSR_MISA:    o_rdata = MISA_VAL;
      CSR_MIE:     o_rdata = w_mie;
      CSR_MTVEC:   o_rdata = r_mtvec;
      CSR_MEPC:    o_rdata = r_mepc;
      CSR_MCAUSE:  o_rdata = r_mcause;
      CSR_MTVAL:   o_rdata = r_mtval;
`ifdef MY_RISCV_IRQ_EN
      CSR_MIP:     o_rdata = {20'b0, i_irqExt, 11'b0};
`endif
      default:     o_rdata = '0;
    endcase
  end

  // Trap entry, MRET and CSR writes are mutually exclusive; the priority order is only a safeguard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatusMie  <= 1'b0;
      r_mstatusMpie <= 1'b0;
      r_mieMeie     <= 1'b0;
      r_mtvec       <= MTVEC_RESET & 32'hFFFF_FFFC;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
    end else if (i_trap) begin
      r_mepc        <= i_trapPc & 32'hFFFF_FFFC;
      r_mcause      <= i_trapCause;
      r_mtval       <= i_trapVal;
      r_mstatusMpie <= r_mstatusMie;
      r_mstatusMie  <= 1'b0;
    end else if (i_mret) begin
      r_mstatusMie  <= r_mstatusMpie;
      r_mstatusMpie <= 1'b1;
    end else if (i_we) begin
      case (i_addr)
        CSR_MSTATUS: begin
          r_mstatusMie  <= i_wdata[MIE_BIT];
          r_mstatusMpie <= i_wdata[MPIE_BIT];
        end
        CSR_MIE:     r_mieMeie <= i_wdata[MEIE_BIT];
        CSR_MTVEC:   r_mtvec   <= i_wdata & 32'hFFFF_FFFC;
        CSR_MEPC:    r_mepc    <= i_wdata & 32'hFFFF_FFFC;
        CSR_MCAUSE:  r_mcause  <= i_wdata;
        CSR_MTVAL:   r_mtval   <= i_wdata;
        default: ;
      endcase
    end
  end

  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;
`ifdef MY_RISCV_IRQ_EN
  assign o_mstatusMie = r_mstatusMie;
  assign o_mieMeie    = r_mieMeie;
`endif

endmodule

// File: rtl/my_riscv_trap_ctrl.sv
// Trap sequencer: CSR decode, exception priority and the RUN/TRAP/RET/WFI FSM.
// MY_RISCV_IRQ_EN enables external interrupts and a stalling WFI; otherwise WFI is a NOP.
module my_riscv_trap_ctrl
  import my_riscv_defines::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic                 clk,
  input  logic                 rst,
  my_riscv_trap_ctrl_if.slave  bus
);

  trap_state_e r_state;
  trap_state_e w_nextState;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1Field;
  logic [11:0] w_imm;
  logic        w_isSystem, w_isCsr, w_isPriv, w_isEcall, w_isMret;
  logic        w_csrIllegal, w_live, w_excTake, w_irqTake, w_trapTake;
  logic        w_mretTake, w_wfiTake, w_writeReq, w_csrWe;
  logic [31:0] w_src, w_rdata, w_wdata, w_cause, w_tval, w_mtvec, w_mepc;
`ifdef MY_RISCV_IRQ_EN
  logic        w_mstatusMie, w_mieMeie, w_irqPending;
`endif

  assign w_opcode   = bus.ex_instr[6:0];
  assign w_funct3   = bus.ex_instr[14:12];
  assign w_rs1Field = bus.ex_instr[19:15];
  assign w_imm      = bus.ex_instr[31:20];

  assign w_isSystem   = (w_opcode == OP_SYSTEM);
  assign w_isCsr      = w_isSystem && (w_funct3 != F3_PRIV);
  assign w_isPriv     = w_isSystem && (w_funct3 == F3_PRIV);
  assign w_isEcall    = w_isPriv && (w_imm == IMM_ECALL);
  assign w_isMret     = w_isPriv && (w_imm == IMM_MRET);
  assign w_csrIllegal = w_isCsr && (!csr_known(w_imm) || (w_funct3 == 3'b100));

  // Immediate forms carry a zero-extended uimm in the rs1 field; RS/RC with a zero field never write.
  assign w_src      = w_funct3[2] ? {27'b0, w_rs1Field} : bus.ex_rs1_data;
  assign w_writeReq = w_isCsr && ((w_funct3[1:0] == 2'b01) || (w_rs1Field != 5'd0));

  always_comb begin
    w_wdata = w_rdata;
    case (w_funct3[1:0])
      2'b01:   w_wdata = w_src;
      2'b10:   w_wdata = w_rdata | w_src;
      2'b11:   w_wdata = w_rdata & ~w_src;
      default: w_wdata = w_rdata;
    endcase
  end

  assign w_live = bus.ex_valid && (r_state == RUN);

`ifdef MY_RISCV_IRQ_EN
  assign w_irqPending = bus.irq_ext && w_mieMeie;
  assign w_irqTake    = w_live && w_mstatusMie && w_irqPending;
  assign w_wfiTake    = w_live && !w_trapTake && w_isPriv && (w_imm == IMM_WFI);
`else
  assign w_irqTake    = 1'b0;
  assign w_wfiTake    = 1'b0;
`endif

  assign w_excTake  = w_live && !w_irqTake &&
                      (bus.ex_misaligned || bus.ex_illegal || w_csrIllegal || w_isEcall);
  assign w_trapTake = w_irqTake || w_excTake;
  assign w_mretTake = w_live && !w_trapTake && w_isMret;
  assign w_csrWe    = w_live && !w_trapTake && w_writeReq;

  always_comb begin
    w_cause = mk_cause(1'b0, CAUSE_ECALL_M);
    w_tval  = '0;
    if (w_irqTake) begin
      w_cause = mk_cause(1'b1, INT_M_EXT);
    end else if (bus.ex_misaligned) begin
      w_cause = mk_cause(1'b0, CAUSE_INSTR_MISALIGNED);
      w_tval  = bus.ex_bad_addr;
    end else if (bus.ex_illegal || w_csrIllegal) begin
      w_cause = mk_cause(1'b0, CAUSE_ILLEGAL_INSTR);
      w_tval  = bus.ex_instr;
    end
  end

  assign bus.csr_rdata = (bus.ex_valid && w_isCsr) ? w_rdata : '0;

  my_riscv_csr_regfile #(
    .MTVEC_RESET (MTVEC_RESET),
    .MISA_VAL    (MISA_VAL)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
`ifdef MY_RISCV_IRQ_EN
    .i_irqExt     (bus.irq_ext),
    .o_mstatusMie (w_mstatusMie),
    .o_mieMeie    (w_mieMeie),
`endif
    .i_addr       (w_imm),
    .i_we         (w_csrWe),
    .i_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .i_trap       (w_trapTake),
    .i_trapPc     (bus.ex_pc),
    .i_trapCause  (w_cause),
    .i_trapVal    (w_tval),
    .i_mret       (w_mretTake),
    .o_mtvec      (w_mtvec),
    .o_mepc       (w_mepc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_nextState;
  end

  // TRAP and RET last exactly one cycle: that cycle carries the redirect and flush.
  always_comb begin
    w_nextState        = r_state;
    bus.redirect_valid = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_pc    = '0;
    bus.stall          = 1'b0;
    case (r_state)
      RUN: begin
        if (w_trapTake)      w_nextState = TRAP;
        else if (w_mretTake) w_nextState = RET;
        else if (w_wfiTake)  w_nextState = WFI;
      end
      TRAP: begin
        bus.redirect_valid = 1'b1;
        bus.flush          = 1'b1;
        bus.redirect_pc    = w_mtvec;
        w_nextState        = RUN;
      end
      RET: begin
        bus.redirect_valid = 1'b1;
        bus.flush          = 1'b1;
        bus.redirect_pc    = w_mepc;
        w_nextState        = RUN;
      end
      WFI: begin
`ifdef MY_RISCV_IRQ_EN
        if (w_irqPending) w_nextState = RUN;
        else              bus.stall   = 1'b1;
`else
        w_nextState = RUN;
`endif
      end
      default: w_nextState = RUN;
    endcase
  end

endmodule

// File: tb/tb_my_riscv_trap_ctrl.sv
// Scoreboard bench for my_riscv_trap_ctrl; feature tests run when MY_RISCV_IRQ_EN is defined.
module tb_my_riscv_trap_ctrl;
  import my_riscv_defines::*;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  localparam logic [31:0] I_ECALL = 32'h0000_0073;
  localparam logic [31:0] I_MRET  = 32'h3020_0073;
  localparam logic [31:0] I_WFI   = 32'h1050_0073;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t        sb[$];
  logic [31:0] obs[$];

  always #5 clk = ~clk;

  my_riscv_trap_ctrl_if bus();

  my_riscv_trap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] csrInstr(input logic [2:0] f3, input logic [11:0] addr,
                                           input logic [4:0] rs1);
    return {addr, rs1, f3, 5'd1, 7'h73};
  endfunction

  task automatic expectVal(input string n, input logic [31:0] v);
    sb.push_back('{n, v});
  endtask

  task automatic observe(input logic [31:0] v);
    obs.push_back(v);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic ill, input logic mis,
                       input logic [31:0] bad);
    bus.ex_valid      = v;
    bus.ex_instr      = instr;
    bus.ex_pc         = pc;
    bus.ex_rs1_data   = rs1;
    bus.ex_illegal    = ill;
    bus.ex_misaligned = mis;
    bus.ex_bad_addr   = bad;
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Reads through CSRRS with rs1 field 0 and a poisoned rs1 value, so a wrongful write would show.
  task automatic readCsr(input string n, input logic [11:0] a, input logic [31:0] expv);
    expectVal(n, expv);
    drive(1'b1, csrInstr(F3_CSRRS, a, 5'd0), 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    observe(bus.csr_rdata);
    tick();
    idle();
  endtask

  task automatic test_reset;
    exp_t e; logic [31:0] got;
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;
    idle();
    expectVal("rst_redirect_valid", 32'd0); observe({31'b0, bus.redirect_valid});
    expectVal("rst_flush", 32'd0);          observe({31'b0, bus.flush});
    expectVal("rst_stall", 32'd0);          observe({31'b0, bus.stall});
    expectVal("rst_redirect_pc", 32'd0);    observe(bus.redirect_pc);
    expectVal("rst_csr_rdata_idle", 32'd0); observe(bus.csr_rdata);
    tick();
    readCsr("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    readCsr("rst_mtvec", CSR_MTVEC, 32'h0000_0100);
    readCsr("rst_mie", CSR_MIE, 32'h0);
    readCsr("rst_mepc", CSR_MEPC, 32'h0);
    readCsr("rst_mcause", CSR_MCAUSE, 32'h0);
    readCsr("rst_mtval", CSR_MTVAL, 32'h0);
    readCsr("rst_misa", CSR_MISA, 32'h4000_0100);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = (obs.size() != 0) ? obs.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  endtask

  task automatic test_csr_ops;
    exp_t e; logic [31:0] got;
    expectVal("csrrw_mtvec_old", 32'h100);
    drive(1'b1, csrInstr(F3_CSRRW, CSR_MTVEC, 5'd5), 32'h10, 32'h0000_0203, 1'b0, 1'b0, 32'h0);
    observe(bus.csr_rdata); tick();
    readCsr("mtvec_warl", CSR_MTVEC, 32'h200);
    expectVal("csrrsi_mstatus_old", 32'h1800);
    drive(1'b1, csrInstr(F3_CSRRSI, CSR_MSTATUS, 5'd8), 32'h14, 32'h0, 1'b0, 1'b0, 32'h0);
    observe(bus.csr_rdata); tick();
    readCsr("mstatus_mie_set", CSR_MSTATUS, 32'h1808);
    expectVal("csrrs_zero_old", 32'h1808);
    drive(1'b1, csrInstr(F3_CSRRSI, CSR_MSTATUS, 5'd0), 32'h18, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    observe(bus.csr_rdata); tick();
    readCsr("mstatus_no_write", CSR_MSTATUS, 32'h1808);
    drive(1'b1, csrInstr(F3_CSRRW, CSR_MIE, 5'd6), 32'h1C, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    tick();
    readCsr("mie_warl", CSR_MIE, 32'h800);
    drive(1'b1, csrInstr(F3_CSRRC, CSR_MIE, 5'd3), 32'h20, 32'h0000_0800, 1'b0, 1'b0, 32'h0);
    tick();
    readCsr("mie_cleared", CSR_MIE, 32'h0);
    expectVal("misa_write_old", 32'h4000_0100);
    drive(1'b1, csrInstr(F3_CSRRW, CSR_MISA, 5'd7), 32'h24, 32'h0, 1'b0, 1'b0, 32'h0);
    observe(bus.csr_rdata); tick();
    readCsr("misa_read_only", CSR_MISA, 32'h4000_0100);
    drive(1'b1, csrInstr(F3_CSRRW, CSR_MEPC, 5'd2), 32'h28, 32'h0000_1237, 1'b0, 1'b0, 32'h0);
    tick();
    readCsr("mepc_warl", CSR_MEPC, 32'h1234);
    drive(1'b1, csrInstr(F3_CSRRWI, CSR_MTVAL, 5'd5), 32'h2C, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    tick();
    readCsr("mtval_csrrwi", CSR_MTVAL, 32'h5);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = (obs.size() != 0) ? obs.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  endtask

  task automatic test_ecall;
    exp_t e; logic [31:0] got;
    expectVal("ecall_n_redirect", 32'd0);
    expectVal("ecall_n_rdata", 32'd0);
    drive(1'b1, I_ECALL, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    observe({31'b0, bus.redirect_valid}); observe(bus.csr_rdata); tick();
    expectVal("ecall_redirect_valid", 32'd1);
    expectVal("ecall_flush", 32'd1);
    expectVal("ecall_redirect_pc", 32'h200);
    drive(1'b1, csrInstr(F3_CSRRW, CSR_MTVEC, 5'd4), 32'h44, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0);
    observe({31'b0, bus.redirect_valid}); observe({31'b0, bus.flush}); observe(bus.redirect_pc);
    tick();
    expectVal("ecall_after_redirect", 32'd0);
    idle(); observe({31'b0, bus.redirect_valid}); tick();
    readCsr("ecall_mepc", CSR_MEPC, 32'h40);
    readCsr("ecall_mcause", CSR_MCAUSE, 32'd11);
    readCsr("ecall_mtval", CSR_MTVAL, 32'h0);
    readCsr("ecall_mstatus", CSR_MSTATUS, 32'h1880);
    readCsr("trap_cycle_ignored", CSR_MTVEC, 32'h200);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = (obs.size() != 0) ? obs.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  endtask

  task automatic test_mret;
    exp_t e; logic [31:0] got;
    expectVal("mret_n_redirect", 32'd0);
    drive(1'b1, I_MRET, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0);
    observe({31'b0, bus.redirect_valid}); tick();
    expectVal("mret_redirect_valid", 32'd1);
    expectVal("mret_flush", 32'd1);
    expectVal("mret_redirect_pc", 32'h40);
    drive(1'b1, csrInstr(F3_CSRRW, CSR_MEPC, 5'd4), 32'h54, 32'h0000_0998, 1'b0, 1'b0, 32'h0);
    observe({31'b0, bus.redirect_valid}); observe({31'b0, bus.flush}); observe(bus.redirect_pc);
    tick();
    idle(); tick();
    readCsr("mret_mstatus", CSR_MSTATUS, 32'h1888);
    readCsr("ret_cycle_ignored", CSR_MEPC, 32'h40);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = (obs.size() != 0) ? obs.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  endtask

  task automatic test_priority;
    exp_t e; logic [31:0] got;
    logic [31:0] badInstr;
    expectVal("prio_redirect_pc", 32'h200);
    drive(1'b1, I_ECALL, 32'h60, 32'h0, 1'b1, 1'b1, 32'h102);
    tick(); idle(); observe(bus.redirect_pc); tick();
    readCsr("prio_mcause", CSR_MCAUSE, 32'd0);
    readCsr("prio_mtval", CSR_MTVAL, 32'h102);
    readCsr("prio_mepc", CSR_MEPC, 32'h60);
    readCsr("prio_mstatus", CSR_MSTATUS, 32'h1880);
    drive(1'b1, I_ECALL, 32'h64, 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); idle(); tick();
    readCsr("ill_over_ecall_mcause", CSR_MCAUSE, 32'd2);
    readCsr("ill_over_ecall_mtval", CSR_MTVAL, I_ECALL);
    readCsr("second_trap_mstatus", CSR_MSTATUS, 32'h1800);
    badInstr = csrInstr(F3_CSRRW, 12'h7C0, 5'd5);
    expectVal("unknown_csr_rdata", 32'h0);
    drive(1'b1, badInstr, 32'h70, 32'h55, 1'b0, 1'b0, 32'h0);
    observe(bus.csr_rdata); tick();
    expectVal("unknown_csr_redirect", 32'd1);
    idle(); observe({31'b0, bus.redirect_valid}); tick();
    readCsr("unknown_csr_mcause", CSR_MCAUSE, 32'd2);
    readCsr("unknown_csr_mtval", CSR_MTVAL, badInstr);
    readCsr("unknown_csr_mepc", CSR_MEPC, 32'h70);
    badInstr = csrInstr(F3_CSRRW, CSR_MTVEC, 5'd5);
    drive(1'b1, badInstr, 32'h74, 32'h300, 1'b1, 1'b0, 32'h0);
    tick(); idle(); tick();
    readCsr("trapping_csr_no_write", CSR_MTVEC, 32'h200);
    readCsr("trapping_csr_mtval", CSR_MTVAL, badInstr);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = (obs.size() != 0) ? obs.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  endtask

  task automatic test_invalid;
    exp_t e; logic [31:0] got;
    expectVal("invalid_ecall_redirect", 32'd0);
    drive(1'b0, I_ECALL, 32'h80, 32'h0, 1'b1, 1'b1, 32'h3);
    tick(); idle(); observe({31'b0, bus.redirect_valid}); tick();
    drive(1'b0, csrInstr(F3_CSRRW, CSR_MTVEC, 5'd5), 32'h84, 32'h500, 1'b0, 1'b0, 32'h0);
    tick();
    readCsr("invalid_no_write", CSR_MTVEC, 32'h200);
`ifndef MY_RISCV_IRQ_EN
    expectVal("wfi_nop_stall", 32'd0);
    expectVal("wfi_nop_next_stall", 32'd0);
    expectVal("wfi_nop_next_redirect", 32'd0);
    drive(1'b1, I_WFI, 32'h88, 32'h0, 1'b0, 1'b0, 32'h0);
    observe({31'b0, bus.stall}); tick();
    idle(); observe({31'b0, bus.stall}); observe({31'b0, bus.redirect_valid}); tick();
    readCsr("mip_illegal_rdata", CSR_MIP, 32'h0);
    idle(); tick();
    readCsr("mip_illegal_mcause", CSR_MCAUSE, 32'd2);
`endif
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = (obs.size() != 0) ? obs.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  endtask

  task automatic test_reset_pending;
    exp_t e; logic [31:0] got;
    rst = 1'b1;
    drive(1'b1, I_ECALL, 32'h90, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    expectVal("rst_drops_redirect", 32'd0);
    expectVal("rst_drops_flush", 32'd0);
    idle(); observe({31'b0, bus.redirect_valid}); observe({31'b0, bus.flush}); tick();
    readCsr("rst_mepc_cleared", CSR_MEPC, 32'h0);
    readCsr("rst_mstatus_again", CSR_MSTATUS, 32'h1800);
    readCsr("rst_mtvec_again", CSR_MTVEC, 32'h100);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = (obs.size() != 0) ? obs.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  endtask

`ifdef MY_RISCV_IRQ_EN
  task automatic test_irq;
    exp_t e; logic [31:0] got;
    drive(1'b1, csrInstr(F3_CSRRW, CSR_MIE, 5'd6), 32'h0, 32'h800, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b1, csrInstr(F3_CSRRSI, CSR_MSTATUS, 5'd8), 32'h4, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    bus.irq_ext = 1'b1;
    expectVal("irq_redirect_valid", 32'd1);
    expectVal("irq_redirect_pc", 32'h100);
    drive(1'b1, csrInstr(F3_CSRRW, CSR_MTVEC, 5'd5), 32'h80, 32'h400, 1'b1, 1'b0, 32'h0);
    tick();
    bus.irq_ext = 1'b0;
    idle(); observe({31'b0, bus.redirect_valid}); observe(bus.redirect_pc); tick();
    readCsr("irq_mcause", CSR_MCAUSE, 32'h8000_000B);
    readCsr("irq_mepc", CSR_MEPC, 32'h80);
    readCsr("irq_mtval", CSR_MTVAL, 32'h0);
    readCsr("irq_instr_not_executed", CSR_MTVEC, 32'h100);
    readCsr("mip_low", CSR_MIP, 32'h0);
    expectVal("wfi_stall_1", 32'd1);
    expectVal("wfi_stall_2", 32'd1);
    expectVal("wfi_wake_same_cycle", 32'd0);
    expectVal("wfi_after_wake", 32'd0);
    drive(1'b1, I_WFI, 32'h84, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    idle(); observe({31'b0, bus.stall}); tick();
    idle(); observe({31'b0, bus.stall}); tick();
    bus.irq_ext = 1'b1;
    idle(); observe({31'b0, bus.stall}); tick();
    idle(); observe({31'b0, bus.stall}); tick();
    readCsr("mip_high", CSR_MIP, 32'h800);
    bus.irq_ext = 1'b0;
    expectVal("wfi_before_reset", 32'd1);
    expectVal("wfi_reset_clears_stall", 32'd0);
    drive(1'b1, I_WFI, 32'h88, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    idle(); observe({31'b0, bus.stall});
    rst = 1'b1; tick();
    idle(); observe({31'b0, bus.stall});
    rst = 1'b0; tick();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = (obs.size() != 0) ? obs.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  endtask
`endif

  initial begin
`ifdef MY_RISCV_IRQ_EN
    bus.irq_ext = 1'b0;
`endif
    rst = 1'b1;
    test_reset();
    test_csr_ops();
    test_ecall();
    test_mret();
    test_priority();
    test_invalid();
    test_reset_pending();
`ifdef MY_RISCV_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_riscv_trap_ctrl.md
Name: my_riscv_trap_ctrl

Overview:
- Machine-mode CSR file and trap sequencer for the RV32I core; sits beside the EX stage.
- Executes CSR instructions (mstatus, misa, mie, mtvec, mepc, mcause, mtval).
- Accepts exception reports for the EX instruction and sequences trap entry, MRET return and WFI.
- Produces a one-cycle fetch redirect and a pipeline flush.
- Opcode, CSR-address and exception-cause constants come from the shared my_riscv_defines package.

Parameters:
- MTVEC_RESET, 32'h0000_0100: reset value of mtvec; bits [1:0] must be 0.
- MISA_VAL, 32'h4000_0100: read-only misa value (RV32, I extension).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage holds a live instruction
- ex_instr  in  32  EX instruction word
- ex_pc  in  32  EX instruction PC
- ex_rs1_data  in  32  rs1 operand, used by CSRRW/S/C
- ex_illegal  in  1  decoder flagged EX instruction illegal
- ex_misaligned  in  1  EX branch/jump target misaligned
- ex_bad_addr  in  32  misaligned target address
- csr_rdata  out  32  old CSR value for rd; 0 when EX is not a CSR op
- flush  out  1  kill IF/ID/EX contents
- redirect_valid  out  1  load redirect_pc into PC
- redirect_pc  out  32  trap vector or mepc
- stall  out  1  freeze fetch and EX (WFI)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state RUN; redirect_valid 0, redirect_pc 0, flush 0, stall 0.
  - mstatus 32'h0000_1800 (MPP=11, MIE=0, MPIE=0); mie 0; mtvec MTVEC_RESET; mepc, mcause, mtval 0.
- CSR decode applies when opcode is OP_SYSTEM and funct3 != 000.
  - CSR address is ex_instr[31:20].
  - Source is ex_rs1_data for funct3 001/010/011, and zero-extended ex_instr[19:15] for 101/110/111.
  - RW writes the source. RS ORs it in. RC clears it (AND with the complement).
  - RS/RC with rs1/uimm field == 0 perform no write.
  - csr_rdata is combinational and returns the pre-write value.
  - Writes commit at the clk edge ending the EX cycle.
- WARL rules:
  - mstatus: only bits 3 (MIE) and 7 (MPIE) are writable; MPP reads 11.
  - mie: only bit 11 (MEIE) is writable.
  - mtvec[1:0] and mepc[1:0] read 0.
  - misa writes are ignored.
  - An unknown CSR address raises the illegal-instruction exception.
- Exception priority within one EX instruction: misaligned (cause 0) > illegal (cause 2) > ECALL (cause 11, SYSTEM with funct3 000 and imm ECALL).
- A trapping instruction performs no CSR write.
- Trap entry, detected in cycle N with ex_valid=1:
  - At the edge ending N: mepc<=ex_pc; mcause<=zero-extended cause; mtval<=ex_bad_addr (misaligned), ex_instr (illegal) or 0 (ECALL); MPIE<=MIE; MIE<=0; state RUN->TRAP.
  - Cycle N+1: redirect_valid=1, flush=1, redirect_pc={mtvec[31:2],2'b00}; state TRAP->RUN.
- MRET (SYSTEM, funct3 000, imm MRET) in cycle N:
  - At the edge ending N: MIE<=MPIE, MPIE<=1; state ->RET.
  - Cycle N+1: redirect_valid=1, flush=1, redirect_pc=mepc; state ->RUN.
- In TRAP and RET states, ex inputs are ignored (the instruction is being flushed).
- WFI (imm WFI): with the feature, state ->WFI, stall=1 (see Optional Feature). Without the feature, WFI is a NOP.
- ex_valid=0: no CSR write, no trap, and the state does not leave RUN.
- Reset asserted in any state returns to RUN with reset values on the next edge; any pending redirect is dropped.

Optional Feature:
- MY_RISCV_IRQ_EN, when defined:
  - Adds input irq_ext (1 bit).
  - mip.MEIP (bit 11) mirrors irq_ext and is readable at 12'h344.
  - When mstatus.MIE & mie.MEIE & irq_ext & ex_valid in RUN, an interrupt is taken. It has priority over all exceptions and the EX instruction is not executed.
  - Interrupt entry: mepc<=ex_pc, mcause<=32'h8000_000B, mtval<=0.
  - WFI enters WFI state with stall=1. It exits to RUN when irq_ext & mie.MEIE, regardless of MIE; stall drops in the same cycle the condition is seen.
- Without the macro: no irq_ext port, mip reads as an illegal address, and WFI is a NOP.

Decomposition:
- Add to my_riscv_defines:
  - MIP 12'h344.
  - Cause codes INT_M_EXT=5'd11 with an interrupt flag.
  - CSR funct3 encodings (CSRRW..CSRRCI).
  - mstatus bit indices MIE_BIT=3, MPIE_BIT=7.
  - typedef enum trap_state_e {RUN, TRAP, RET, WFI}.
- One sub-module, my_riscv_csr_regfile: CSR storage, WARL masking and read mux. my_riscv_trap_ctrl keeps decode, priority and the FSM.

Test Plan:
- CSR ops:
  - CSRRW mtvec with rs1=0x0000_0203 → csr_rdata=0x100; mtvec reads 0x0000_0200.
  - CSRRS mstatus with uimm=0 → no write.
- ECALL at pc 0x40 with mtvec=0x200, MIE=1:
  - N+1: redirect_valid=1, redirect_pc=0x200, flush=1.
  - mepc=0x40, mcause=11, mtval=0, MIE=0, MPIE=1.
- Same instruction flagged ex_illegal and ex_misaligned (bad_addr 0x102) → mcause=0, mtval=0x102.
- CSRRW to address 0x7C0 → illegal trap; mtval=instruction word; target CSR unchanged.
- MRET after the ECALL → redirect_pc=0x40, MIE=1, MPIE=1; ex inputs during the TRAP/RET cycle are ignored.
- Feature on:
  - MIE=1, MEIE=1, irq_ext=1 at pc 0x80 → mcause=0x8000_000B, mepc=0x80.
  - WFI with irq low → stall=1 until irq_ext rises.
  - Reset mid-WFI → stall=0 on the next edge.
